motor_pwm_driver: RTL and testbench
===================================

Name: motor_pwm_driver

Overview:
- Consumer end of the left/right motor-command FIFOs filled by the steering-to-motor stage.
- Pops one left/right speed pair at a time, double-buffers it, and applies it only at a PWM period boundary.
- Drives two registered PWM pins to the motor H-bridges.
- A watchdog forces both duties to zero when commands stop arriving.

Parameters:
- MOTOR_WIDTH, 8, width of each speed word and of the PWM tick counter; period = 2^MOTOR_WIDTH ticks.
- PRESCALE, 4, clk cycles per PWM tick; must be >= 1.
- WATCHDOG_PERIODS, 16, consecutive periods without a new command before timeout; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_left_motor  in  MOTOR_WIDTH  left FIFO read data; valid the cycle after o_left_rd_en
- i_left_empty  in  1  left FIFO empty
- o_left_rd_en  out  1  left FIFO pop
- i_right_motor  in  MOTOR_WIDTH  right FIFO read data; valid the cycle after o_right_rd_en
- i_right_empty  in  1  right FIFO empty
- o_right_rd_en  out  1  right FIFO pop
- o_left_pwm  out  1  left motor PWM
- o_right_pwm  out  1  right motor PWM
- o_timeout  out  1  watchdog expired; duties forced to 0

Behaviour:
- Reset (async, immediate):
  - all outputs 0
  - state S_IDLE; prescaler, tick counter and watchdog count cleared
  - active and pending duties 0; pending_valid 0
- Timebase:
  - Prescaler counts 0..PRESCALE-1.
  - On wrap, the tick counter increments 0..2^MOTOR_WIDTH-1, then wraps to 0.
  - Boundary = cycle where prescaler==PRESCALE-1 and tick==max.
- PWM:
  - o_x_pwm <= (tick < active_x), registered, 1-cycle latency.
  - Duty 0 never goes high; duty 255 (MW=8) is high 255 of 256 ticks; no 100% duty.
- FSM:
  - S_IDLE: if !i_left_empty && !i_right_empty, assert both rd_en for exactly one cycle -> S_CAPTURE. If either FIFO is empty, no pop and stay; the two FIFOs are never popped independently.
  - S_CAPTURE: latch i_left_motor/i_right_motor into pending; pending_valid<=1 -> S_HOLD.
  - S_HOLD: wait until pending_valid==0 -> S_IDLE.
  - At most one command is consumed per period; back-pressure is held in the FIFOs.
- Boundary update, using values present before the edge:
  - If pending_valid: active<=pending; pending_valid<=0; watchdog<=0; o_timeout<=0.
  - Else: watchdog saturating-increments. When it reaches WATCHDOG_PERIODS: active<=0 for both sides, o_timeout<=1.
  - A pending value written in S_CAPTURE on the same cycle as a boundary is not applied until the next boundary.
- New duties take effect from tick 0 of the next period; no mid-period glitches.
- o_timeout stays high until the first boundary that applies a new command.
- Reset mid-period or mid-handshake: a popped-but-unapplied command is discarded; no re-pop is attempted.

Decomposition:
- Shared package motor_pkg:
  - MOTOR_WIDTH default constant
  - state typedef pwm_drv_state_t {S_IDLE, S_CAPTURE, S_HOLD}
- Sub-module pwm_timebase (prescaler + tick counter).
  - Outputs: tick value and boundary pulse.
  - Instantiated once; shared by both channels.

Test Plan:
All cases use MW=8, PRESCALE=1 (period 256 cycles) unless noted.
- Reset: hold reset 5 cycles with both FIFOs non-empty -> all outputs 0, no rd_en. Release -> rd_en pair pulses exactly one cycle on the first clock.
- Basic duty: push L=64, R=192 -> one rd_en pulse pair. From the period after the next boundary, o_left_pwm high 64 of 256 cycles and o_right_pwm high 192 of 256, repeating.
- One-sided empty: left holds 3 entries, right empty for 1000 cycles -> no rd_en on either side; duties unchanged. Push right=10 -> single paired pop.
- Back-pressure: preload 4 pairs with the FIFOs never empty -> exactly one pop per period; duty changes only at boundaries, in FIFO order.
- Watchdog (WATCHDOG_PERIODS=4): one command 128/128, then silence -> after 4 boundaries without a command both PWMs stay low and o_timeout=1. Push 100/100 -> o_timeout clears at the applying boundary; 100-cycle pulses resume.
- Extremes and async reset:
  - Duty 0 -> pin never high; duty 255 -> low exactly 1 cycle per period.
  - Assert reset asynchronously mid-pulse -> PWM pins drop without waiting for a clock edge; pending command lost.

Source files
------------

// File: rtl/motor_pkg.sv
// motor_pkg: shared speed-word width default and motor driver FSM state type
package motor_pkg;
  localparam int MOTOR_WIDTH_DEFAULT = 8;
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HOLD} pwm_drv_state_t;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus PWM tick counter; ports clk, reset -> tick (current tick), boundary (last clk of a period)
module pwm_timebase #(
  parameter int MOTOR_WIDTH = 8,
  parameter int PRESCALE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [MOTOR_WIDTH-1:0] tick,
  output logic                   boundary
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre;
  logic wrap;
  assign wrap = pre == PW'(PRESCALE - 1);
  assign boundary = wrap && &tick;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre  <= '0;
      tick <= '0;
    end else begin
      pre <= wrap ? '0 : pre + 1'b1;
      if (wrap) tick <= tick + 1'b1;
    end
  end
endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: pops paired L/R speeds from FIFOs (i_*_motor, i_*_empty -> o_*_rd_en), applies them at period boundaries to o_left_pwm/o_right_pwm, o_timeout when commands stop
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int MOTOR_WIDTH = MOTOR_WIDTH_DEFAULT,
  parameter int PRESCALE = 4,
  parameter int WATCHDOG_PERIODS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MOTOR_WIDTH-1:0] i_left_motor,
  input  logic                   i_left_empty,
  output logic                   o_left_rd_en,
  input  logic [MOTOR_WIDTH-1:0] i_right_motor,
  input  logic                   i_right_empty,
  output logic                   o_right_rd_en,
  output logic                   o_left_pwm,
  output logic                   o_right_pwm,
  output logic                   o_timeout
);
  localparam int WW = $clog2(WATCHDOG_PERIODS + 1);
  pwm_drv_state_t state, state_nxt;
  logic [MOTOR_WIDTH-1:0] tick, pend_l, pend_r, act_l, act_r;
  logic boundary, pend_v, both_ready, wd_hit, pop;
  logic [WW-1:0] wd;
  assign both_ready = !i_left_empty && !i_right_empty;
  assign wd_hit = wd >= WW'(WATCHDOG_PERIODS - 1);
  pwm_timebase #(.MOTOR_WIDTH(MOTOR_WIDTH), .PRESCALE(PRESCALE)) u_timebase (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .boundary(boundary)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == S_IDLE    ? (both_ready ? S_CAPTURE : S_IDLE) :
                state == S_CAPTURE ? S_HOLD :
                pend_v             ? S_HOLD : S_IDLE;
  end
  // Pop is combinational so read data lands in S_CAPTURE; masked while reset is held so no pop escapes.
  always_comb begin
    pop = state == S_IDLE && both_ready && !reset;
    o_left_rd_en = pop;
    o_right_rd_en = pop;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_left_pwm  <= 1'b0;
      o_right_pwm <= 1'b0;
      o_timeout   <= 1'b0;
      act_l       <= '0;
      act_r       <= '0;
      pend_l      <= '0;
      pend_r      <= '0;
      pend_v      <= 1'b0;
      wd          <= '0;
    end else begin
      o_left_pwm  <= tick < act_l;
      o_right_pwm <= tick < act_r;
      if (boundary) begin
        if (pend_v) begin
          act_l     <= pend_l;
          act_r     <= pend_r;
          pend_v    <= 1'b0;
          wd        <= '0;
          o_timeout <= 1'b0;
        end else begin
          wd <= wd_hit ? WW'(WATCHDOG_PERIODS) : wd + 1'b1;
          if (wd_hit) begin
            act_l     <= '0;
            act_r     <= '0;
            o_timeout <= 1'b1;
          end
        end
      end
      // A capture coinciding with a boundary sets pend_v after the boundary looked at it, so it waits a period.
      if (state == S_CAPTURE) begin
        pend_l <= i_left_motor;
        pend_r <= i_right_motor;
        pend_v <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: randomized self-checking bench with a period-level reference model of the motor driver
module tb_motor_pwm_driver;
  localparam int MW = 8;
  localparam int PS = 1;
  localparam int WDP = 4;
  localparam int PER = (1 << MW) * PS;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [MW-1:0] i_left_motor = '0;
  logic [MW-1:0] i_right_motor = '0;
  logic i_left_empty = 1'b1;
  logic i_right_empty = 1'b1;
  logic o_left_rd_en, o_right_rd_en, o_left_pwm, o_right_pwm, o_timeout;
  int errors = 0;
  int checks = 0;
  logic [MW-1:0] lq[$];
  logic [MW-1:0] rq[$];
  int cyc;
  int m_ready_at, m_pend_b, m_wd, m_ptick;
  bit m_pend, m_tmo;
  logic [MW-1:0] m_pl, m_pr, m_al, m_ar, m_pal, m_par;
  int pwm_mis, rd_mis, tmo_mis, pops, hi_l, hi_r;
  int win_l[$];
  int win_r[$];
  always #5 clk = ~clk;
  motor_pwm_driver #(.MOTOR_WIDTH(MW), .PRESCALE(PS), .WATCHDOG_PERIODS(WDP)) dut (
    .clk(clk),
    .reset(reset),
    .i_left_motor(i_left_motor),
    .i_left_empty(i_left_empty),
    .o_left_rd_en(o_left_rd_en),
    .i_right_motor(i_right_motor),
    .i_right_empty(i_right_empty),
    .o_right_rd_en(o_right_rd_en),
    .o_left_pwm(o_left_pwm),
    .o_right_pwm(o_right_pwm),
    .o_timeout(o_timeout)
  );
  task automatic model_init();
    m_ready_at = 0; m_pend = 0; m_pend_b = -1; m_wd = 0; m_tmo = 0;
    m_al = '0; m_ar = '0; m_pal = '0; m_par = '0; m_ptick = 0; cyc = 0;
    pwm_mis = 0; rd_mis = 0; tmo_mis = 0; pops = 0; hi_l = 0; hi_r = 0;
    win_l.delete(); win_r.delete();
  endtask
  task automatic model_cycle();
    bit bnd, exp_rd, el, er;
    bnd = (cyc % PER) == PER - 1;
    exp_rd = cyc >= m_ready_at && lq.size() > 0 && rq.size() > 0;
    el = cyc > 0 && m_ptick < int'(m_pal);
    er = cyc > 0 && m_ptick < int'(m_par);
    if (o_left_rd_en !== exp_rd || o_right_rd_en !== exp_rd) rd_mis++;
    if (o_timeout !== m_tmo) tmo_mis++;
    if (o_left_pwm !== el || o_right_pwm !== er) pwm_mis++;
    if (o_left_rd_en === 1'b1 && o_right_rd_en === 1'b1) pops++;
    if (cyc > 0) begin
      hi_l += int'(o_left_pwm === 1'b1);
      hi_r += int'(o_right_pwm === 1'b1);
      if ((cyc - 1) % PER == PER - 1) begin
        win_l.push_back(hi_l);
        win_r.push_back(hi_r);
        hi_l = 0;
        hi_r = 0;
      end
    end
    m_ptick = (cyc / PS) % (1 << MW);
    m_pal = m_al;
    m_par = m_ar;
    if (exp_rd) begin
      m_pl = lq[0];
      m_pr = rq[0];
      m_pend = 1;
      m_pend_b = cyc + 2 + (PER - 1 - (cyc + 2) % PER);
      m_ready_at = 1 << 30;
    end
    if (bnd) begin
      if (m_pend && m_pend_b == cyc) begin
        m_al = m_pl; m_ar = m_pr; m_pend = 0; m_wd = 0; m_tmo = 0; m_ready_at = cyc + 2;
      end else begin
        m_wd = m_wd < WDP ? m_wd + 1 : WDP;
        if (m_wd == WDP) begin
          m_al = '0; m_ar = '0; m_tmo = 1;
        end
      end
    end
  endtask
  task automatic step();
    bit lr, rr;
    #1;
    model_cycle();
    lr = o_left_rd_en;
    rr = o_right_rd_en;
    @(posedge clk);
    #1;
    if (lr && lq.size() > 0) i_left_motor = lq.pop_front();
    if (rr && rq.size() > 0) i_right_motor = rq.pop_front();
    i_left_empty = lq.size() == 0;
    i_right_empty = rq.size() == 0;
    cyc++;
    @(negedge clk);
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic push(input logic [MW-1:0] l, input logic [MW-1:0] r, input bit dl, input bit dr);
    if (dl) lq.push_back(l);
    if (dr) rq.push_back(r);
    i_left_empty = lq.size() == 0;
    i_right_empty = rq.size() == 0;
  endtask
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_init();
  endtask
  task automatic test_reset();
    int viol;
    viol = 0;
    push(8'd20, 8'd30, 1, 1);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if ({o_left_rd_en, o_right_rd_en, o_left_pwm, o_right_pwm, o_timeout} !== 5'b0) viol++;
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL reset_hold: %0d cycles with outputs active, want 0", viol); end
    reset = 1'b0;
    model_init();
    #1;
    checks++; if ({o_left_rd_en, o_right_rd_en} !== 2'b11) begin errors++; $display("FAIL reset_first_pop: rd_en=%b want 11", {o_left_rd_en, o_right_rd_en}); end
    step();
    #1;
    checks++; if ({o_left_rd_en, o_right_rd_en} !== 2'b00) begin errors++; $display("FAIL reset_pop_width: rd_en=%b want 00", {o_left_rd_en, o_right_rd_en}); end
    run(599);
    checks++; if (pops !== 1) begin errors++; $display("FAIL reset_pops: got %0d want 1", pops); end
    checks++; if (win_l[1] !== 20 || win_r[1] !== 30) begin errors++; $display("FAIL reset_duty: got %0d/%0d want 20/30", win_l[1], win_r[1]); end
    checks++; if (rd_mis + pwm_mis + tmo_mis !== 0) begin errors++; $display("FAIL reset_model: rd=%0d pwm=%0d tmo=%0d want 0", rd_mis, pwm_mis, tmo_mis); end
  endtask
  task automatic test_basic_duty();
    do_reset(2);
    run(10);
    push(8'd64, 8'd192, 1, 1);
    run(790);
    checks++; if (pops !== 1) begin errors++; $display("FAIL basic_pops: got %0d want 1", pops); end
    for (int k = 1; k <= 2; k++) begin
      checks++; if (win_l[k] !== 64 || win_r[k] !== 192) begin errors++; $display("FAIL basic_duty p%0d: got %0d/%0d want 64/192", k, win_l[k], win_r[k]); end
    end
    checks++; if (win_l[0] !== 0 || win_r[0] !== 0) begin errors++; $display("FAIL basic_pre_apply: got %0d/%0d want 0/0", win_l[0], win_r[0]); end
    checks++; if (rd_mis + pwm_mis + tmo_mis !== 0) begin errors++; $display("FAIL basic_model: rd=%0d pwm=%0d tmo=%0d want 0", rd_mis, pwm_mis, tmo_mis); end
  endtask
  task automatic test_one_sided();
    do_reset(2);
    push(8'd5, 8'd0, 1, 0);
    push(8'd6, 8'd0, 1, 0);
    push(8'd7, 8'd0, 1, 0);
    run(1000);
    checks++; if (pops !== 0 || rd_mis !== 0) begin errors++; $display("FAIL one_sided_nopop: pops=%0d rd_mis=%0d want 0/0", pops, rd_mis); end
    checks++; if (lq.size() !== 3) begin errors++; $display("FAIL one_sided_left_depth: got %0d want 3", lq.size()); end
    push(8'd0, 8'd10, 0, 1);
    run(600);
    checks++; if (pops !== 1) begin errors++; $display("FAIL one_sided_pair_pop: got %0d want 1", pops); end
    checks++; if (win_l[4] !== 5 || win_r[4] !== 10) begin errors++; $display("FAIL one_sided_duty: got %0d/%0d want 5/10", win_l[4], win_r[4]); end
    checks++; if (rd_mis + pwm_mis + tmo_mis !== 0) begin errors++; $display("FAIL one_sided_model: rd=%0d pwm=%0d tmo=%0d want 0", rd_mis, pwm_mis, tmo_mis); end
    lq.delete();
    push(8'd0, 8'd0, 0, 0);
  endtask
  task automatic test_back_to_back();
    logic [MW-1:0] cl[4];
    logic [MW-1:0] cr[4];
    for (int k = 0; k < 4; k++) begin
      cl[k] = MW'($urandom);
      cr[k] = MW'($urandom);
      push(cl[k], cr[k], 1, 1);
    end
    do_reset(2);
    run(5 * PER + 10);
    checks++; if (pops !== 4) begin errors++; $display("FAIL b2b_pops: got %0d want 4", pops); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (win_l[k+1] !== int'(cl[k]) || win_r[k+1] !== int'(cr[k])) begin errors++; $display("FAIL b2b_order p%0d: got %0d/%0d want %0d/%0d", k + 1, win_l[k+1], win_r[k+1], cl[k], cr[k]); end
    end
    checks++; if (rd_mis + pwm_mis + tmo_mis !== 0) begin errors++; $display("FAIL b2b_model: rd=%0d pwm=%0d tmo=%0d want 0", rd_mis, pwm_mis, tmo_mis); end
  endtask
  task automatic test_watchdog();
    push(8'd128, 8'd128, 1, 1);
    do_reset(2);
    run(1400);
    #1;
    checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL wd_timeout_set: got %b want 1", o_timeout); end
    checks++; if (win_l[4] !== 128 || win_r[4] !== 128) begin errors++; $display("FAIL wd_last_live: got %0d/%0d want 128/128", win_l[4], win_r[4]); end
    run(200);
    checks++; if (win_l[5] !== 0 || win_r[5] !== 0) begin errors++; $display("FAIL wd_forced_zero: got %0d/%0d want 0/0", win_l[5], win_r[5]); end
    push(8'd100, 8'd100, 1, 1);
    run(190);
    #1;
    checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL wd_hold_until_apply: got %b want 1", o_timeout); end
    run(310);
    #1;
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL wd_timeout_clear: got %b want 0", o_timeout); end
    checks++; if (win_l[7] !== 100 || win_r[7] !== 100) begin errors++; $display("FAIL wd_resume: got %0d/%0d want 100/100", win_l[7], win_r[7]); end
    checks++; if (rd_mis + pwm_mis + tmo_mis !== 0) begin errors++; $display("FAIL wd_model: rd=%0d pwm=%0d tmo=%0d want 0", rd_mis, pwm_mis, tmo_mis); end
  endtask
  task automatic test_extremes();
    push(8'd0, 8'd255, 1, 1);
    do_reset(2);
    run(800);
    for (int k = 1; k <= 2; k++) begin
      checks++; if (win_l[k] !== 0 || win_r[k] !== 255) begin errors++; $display("FAIL extreme_duty p%0d: got %0d/%0d want 0/255", k, win_l[k], win_r[k]); end
    end
    checks++; if (pwm_mis !== 0) begin errors++; $display("FAIL extreme_model: pwm=%0d want 0", pwm_mis); end
  endtask
  task automatic test_async_reset();
    push(8'd200, 8'd50, 1, 1);
    do_reset(2);
    run(300);
    push(8'd77, 8'd77, 1, 1);
    run(2);
    #2;
    checks++; if ({o_left_pwm, o_right_pwm} !== 2'b11) begin errors++; $display("FAIL async_pre_high: pwm=%b want 11", {o_left_pwm, o_right_pwm}); end
    reset = 1'b1;
    #1;
    checks++; if ({o_left_pwm, o_right_pwm, o_timeout} !== 3'b000) begin errors++; $display("FAIL async_drop: pwm/tmo=%b want 000", {o_left_pwm, o_right_pwm, o_timeout}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_init();
    run(600);
    checks++; if (pops !== 0) begin errors++; $display("FAIL async_no_repop: got %0d want 0", pops); end
    checks++; if (win_l[1] !== 0 || win_r[1] !== 0) begin errors++; $display("FAIL async_pending_lost: got %0d/%0d want 0/0", win_l[1], win_r[1]); end
    checks++; if (rd_mis + pwm_mis !== 0) begin errors++; $display("FAIL async_model: rd=%0d pwm=%0d want 0", rd_mis, pwm_mis); end
  endtask
  task automatic test_random();
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      run($urandom_range(0, 600));
      push(MW'($urandom), MW'($urandom), 1, 1);
    end
    run(12 * PER);
    checks++; if (lq.size() !== 0 || rq.size() !== 0) begin errors++; $display("FAIL random_drain: left=%0d right=%0d want 0/0", lq.size(), rq.size()); end
    checks++; if (pops !== 8) begin errors++; $display("FAIL random_pops: got %0d want 8", pops); end
    checks++; if (rd_mis + pwm_mis + tmo_mis !== 0) begin errors++; $display("FAIL random_model: rd=%0d pwm=%0d tmo=%0d want 0", rd_mis, pwm_mis, tmo_mis); end
  endtask
  initial begin
    test_reset();
    test_basic_duty();
    test_one_sided();
    test_back_to_back();
    test_watchdog();
    test_extremes();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
